// File: rtl/stream_arb_pkg.sv
// Shared defaults and lock-state encoding for the stream arbiter slice.
package stream_arb_pkg;

   localparam int NUM_REQ_DEF    = 4;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int ID_WIDTH_DEF   = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

endpackage

// File: rtl/stream_arbiter_if.sv
// Request/merged-output bundle of the stream arbiter; slave is the arbiter's view.
// Handshake: a beat moves on a rising edge where valid and ready are both high; ready may depend on valid.
interface stream_arbiter_if
   import stream_arb_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ID_WIDTH   = ID_WIDTH_DEF
) ();

   logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn;
   logic [NUM_REQ-1:0]            reqLastIn;
   logic [NUM_REQ-1:0]            reqValidIn;
   logic [NUM_REQ-1:0]            reqReadyOut;
   logic [DATA_WIDTH-1:0]         outDataOut;
   logic                          outLastOut;
   logic [ID_WIDTH-1:0]           outIdOut;
   logic                          outValidOut;
   logic                          outReadyIn;

   modport slave (
      input  reqDataIn, reqLastIn, reqValidIn, outReadyIn,
      output reqReadyOut, outDataOut, outLastOut, outIdOut, outValidOut
   );

   modport master (
      output reqDataIn, reqLastIn, reqValidIn, outReadyIn,
      input  reqReadyOut, outDataOut, outLastOut, outIdOut, outValidOut
   );

endinterface

// File: rtl/stream_arbiter_rr_select.sv
// rr_select: combinational masked round-robin pick, first set request at or above ptr, wrapping.
module rr_select
   import stream_arb_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int ID_WIDTH = ID_WIDTH_DEF
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] idx
);

   always_comb begin
      logic                found;
      logic [ID_WIDTH:0]   cand;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // One extra bit so ptr+k never overflows before the modulo wrap.
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (ID_WIDTH+1)'(k);
         if (cand >= (ID_WIDTH+1)'(NUM_REQ)) cand = cand - (ID_WIDTH+1)'(NUM_REQ);
         if (!found && req[cand[ID_WIDTH-1:0]]) begin
            found                     = 1'b1;
            grant[cand[ID_WIDTH-1:0]] = 1'b1;
            idx                       = cand[ID_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin merge of NUM_REQ streams into one registered output stage.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant from first beat to reqLastIn of a packet.
module stream_arbiter
   import stream_arb_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
   input  logic                clkIn,
   input  logic                rstIn,
   stream_arbiter_if.slave     bus,
   output logic [ID_WIDTH-1:0] dbgRrPtr,
   output lock_state_t         dbgLockState
);

   logic [ID_WIDTH-1:0] rrPtr;
   logic [NUM_REQ-1:0]  rrGrant;
   logic [ID_WIDTH-1:0] rrIdx;
   logic [NUM_REQ-1:0]  grantVec;
   logic [ID_WIDTH-1:0] grantee;
   logic                canLoad;
   logic                accept;
   logic                relArb;

   rr_select #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_sel (
      .req   (bus.reqValidIn),
      .ptr   (rrPtr),
      .grant (rrGrant),
      .idx   (rrIdx)
   );

   assign canLoad = !bus.outValidOut || bus.outReadyIn;

`ifdef STREAM_ARB_PKT_LOCK_EN
   lock_state_t         lockState;
   logic [ID_WIDTH-1:0] lockId;

   // While locked the owner keeps the grant even when it momentarily drops valid.
   always_comb begin
      grantVec = rrGrant;
      grantee  = rrIdx;
      if (lockState == LOCKED) begin
         grantVec         = '0;
         grantVec[lockId] = 1'b1;
         grantee          = lockId;
      end
   end

   assign relArb       = bus.reqLastIn[grantee];
   assign dbgLockState = lockState;

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         lockState <= IDLE;
         lockId    <= '0;
      end else if (accept) begin
         lockState <= bus.reqLastIn[grantee] ? IDLE : LOCKED;
         lockId    <= grantee;
      end
   end
`else
   assign grantVec     = rrGrant;
   assign grantee      = rrIdx;
   assign relArb       = 1'b1;
   assign dbgLockState = IDLE;
`endif

   assign accept          = !rstIn && canLoad && |(grantVec & bus.reqValidIn);
   assign bus.reqReadyOut = (!rstIn && canLoad) ? (grantVec & bus.reqValidIn) : '0;
   assign dbgRrPtr        = rrPtr;

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         bus.outValidOut <= 1'b0;
         bus.outDataOut  <= '0;
         bus.outLastOut  <= 1'b0;
         bus.outIdOut    <= '0;
         rrPtr           <= '0;
      end else begin
         if (canLoad) bus.outValidOut <= accept;
         if (accept) begin
            bus.outDataOut <= bus.reqDataIn[grantee*DATA_WIDTH +: DATA_WIDTH];
            bus.outLastOut <= bus.reqLastIn[grantee];
            bus.outIdOut   <= grantee;
            if (relArb) rrPtr <= (grantee == ID_WIDTH'(NUM_REQ-1)) ? '0 : grantee + 1'b1;
         end
      end
   end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester streams (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, beat width.
REQ-003 SHALL have parameter ID_WIDTH, default 2, grant index width, equal to ceil(log2(NUM_REQ)).
REQ-004 SHALL have port clkIn, input, 1, single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rstIn, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port reqDataIn, input, NUM_REQ*DATA_WIDTH, requester i beat in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port reqLastIn, input, NUM_REQ, per-requester last-beat-of-packet flag.
REQ-008 SHALL have port reqValidIn, input, NUM_REQ, per-requester valid.
REQ-009 SHALL have port reqReadyOut, output, NUM_REQ, per-requester ready.
REQ-010 SHALL have port outDataOut, output, DATA_WIDTH, merged beat, typically driving a fifo write port.
REQ-011 SHALL have port outLastOut, output, 1, last flag of the merged beat.
REQ-012 SHALL have port outIdOut, output, ID_WIDTH, index of the requester that sourced the merged beat.
REQ-013 SHALL have port outValidOut, output, 1, merged beat valid.
REQ-014 SHALL have port outReadyIn, input, 1, downstream ready.

Function
REQ-015 SHALL transfer a beat on any port when valid and ready are both high on the same rising edge.
REQ-016 SHALL hold the output in a single registered stage; latency from accepted request beat to outValidOut is 1 cycle.
REQ-017 SHALL treat the output stage as able to load when it is empty or outReadyIn is high; reqReadyOut[g] = load-able AND g is the grantee; all other reqReadyOut bits are 0.
REQ-018 SHALL sustain one beat per cycle when outReadyIn is held high and a requester stays valid.
REQ-019 SHALL select the grantee round-robin: the lowest valid index at or above pointer rrPtr, wrapping past NUM_REQ-1 to 0.
REQ-020 SHALL set rrPtr to (grantee+1) mod NUM_REQ on every arbitration-releasing transfer (REQ-024/REQ-025); rrPtr wraps from NUM_REQ-1 to 0.
REQ-021 SHALL hold outDataOut, outLastOut and outIdOut stable while outValidOut=1 and outReadyIn=0.
REQ-022 SHALL, with no requester valid, assert no reqReadyOut bit, leave rrPtr unchanged, and clear outValidOut after the pending output is consumed.
REQ-023 SHALL, when a beat is consumed and a new beat is loaded on the same edge, keep outValidOut high with the new beat.

Configuration
REQ-024 SHALL, when macro STREAM_ARB_PKT_LOCK_EN is defined, keep a lock state (IDLE, LOCKED): an accepted non-last beat enters LOCKED on the grantee; LOCKED holds the grant even if that requester drops valid; an accepted last beat returns to IDLE and releases arbitration.
REQ-025 SHALL, when STREAM_ARB_PKT_LOCK_EN is undefined, re-arbitrate after every accepted beat, pass reqLastIn through to outLastOut without interpretation, and contain no lock state.

Reset
REQ-026 SHALL, while rstIn=1, drive outValidOut=0, reqReadyOut=0, outDataOut=0, outLastOut=0, outIdOut=0, rrPtr=0 and lock state IDLE.
REQ-027 SHALL discard any pending output beat or partial packet when reset asserts mid-operation; no beat is accepted on an edge where rstIn=1.

Structure
REQ-028 SHALL place the NUM_REQ and ID_WIDTH defaults and the IDLE/LOCKED state encodings in shared package stream_arb_pkg.
REQ-029 SHALL implement the masked round-robin pick as combinational sub-module rr_select, with inputs request vector and pointer, and outputs one-hot grant and index.

Verification
REQ-030 SHALL verify reset: rstIn high 3 cycles with all reqValidIn=4'b1111 -> outValidOut=0, reqReadyOut=0 throughout.
REQ-031 SHALL verify fairness: all 4 requesters valid with single-beat packets, outReadyIn=1 -> outIdOut sequence 0,1,2,3,0 on consecutive cycles, first beat 1 cycle after reset release.
REQ-032 SHALL verify backpressure: outReadyIn=0 for 5 cycles with data 32'hA5A5_0001 pending -> output held stable, reqReadyOut=0; on release -> next beat follows with no gap.
REQ-033 SHALL verify locking (lock enabled): requester 2 sends 4-beat packet, requester 0 valid throughout, requester 2 idles 2 cycles mid-packet -> outIdOut=2 for all 4 beats, then 0.
REQ-034 SHALL verify the unlocked build: same stimulus as REQ-033 -> beats interleave 2,0,2,0.
REQ-035 SHALL verify wrap and reset mid-packet: rrPtr=3 with only requester 1 valid -> grant 1; rstIn pulsed after beat 2 of 4 -> lock cleared, rrPtr=0.
